// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV32I decode stage with valid/ready handshake and flush.
// Define DECODE_ILLEGAL_TRAP_EN to register an illegal flag; otherwise illegal encodings decode as NOP.
module instr_decode_stage #(
  parameter int REG_ADDR_W    = 5,
  parameter bit ZERO_RD_NO_WE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [31:0]           pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           pc_out,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic                  src_sel,
  output logic                  alu_en,
  output logic                  op_a_pc,
  output logic [31:0]           immediate,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rd_we,
  output logic [2:0]            cls,
  output logic                  illegal
);
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BR = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [2:0] CLS_ALU = 3'd0, CLS_LOAD = 3'd1, CLS_STORE = 3'd2, CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JAL = 3'd4, CLS_JALR = 3'd5, CLS_NOP = 3'd6;
  localparam logic [6:0] ALT = 7'b0100000;
  typedef struct packed {
    logic [31:0]           pc;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic                  src;
    logic                  alu;
    logic                  apc;
    logic [31:0]           imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [2:0]            cls;
  } bundle_t;
  bundle_t d, q;
  logic bad;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic load;
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  always_comb begin
    d = '0;
    d.pc = pc;
    d.rs1 = instr[15 +: REG_ADDR_W];
    d.rs2 = instr[20 +: REG_ADDR_W];
    d.rd = instr[7 +: REG_ADDR_W];
    d.cls = CLS_NOP;
    bad = 1'b0;
    case (instr[6:0])
      OP: begin
        d.f3 = f3; d.f7 = f7; d.src = 1'b1; d.alu = 1'b1; d.we = 1'b1; d.cls = CLS_ALU;
        bad = !(f7 == '0 || (f7 == ALT && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPI: begin
        d.f3 = f3; d.f7 = (f3 == 3'b001 || f3 == 3'b101) ? f7 : '0;
        d.alu = 1'b1; d.imm = imm_i; d.we = 1'b1; d.cls = CLS_ALU;
        bad = f3 == 3'b001 ? f7 != '0 : f3 == 3'b101 ? !(f7 == '0 || f7 == ALT) : 1'b0;
      end
      LUI, AUIPC: begin
        d.rs1 = '0; d.alu = 1'b1; d.imm = imm_u; d.we = 1'b1; d.cls = CLS_ALU;
        d.apc = instr[6:0] == AUIPC;
      end
      LOAD:  begin d.alu = 1'b1; d.imm = imm_i; d.we = 1'b1; d.cls = CLS_LOAD; end
      STORE: begin d.alu = 1'b1; d.imm = imm_s; d.cls = CLS_STORE; end
      BR:    begin d.f3 = f3; d.src = 1'b1; d.imm = imm_b; d.cls = CLS_BRANCH; end
      JAL:   begin d.imm = imm_j; d.we = 1'b1; d.cls = CLS_JAL; end
      JALR:  begin d.alu = 1'b1; d.imm = imm_i; d.we = 1'b1; d.cls = CLS_JALR; end
      default: bad = 1'b1;
    endcase
    d.we = d.we & !(ZERO_RD_NO_WE && d.rd == '0);
    if (bad) begin
      d = '0;
      d.pc = pc;
      d.cls = CLS_NOP;
    end
  end
  assign in_ready = !out_valid | out_ready;
  assign load = in_valid & in_ready & !flush;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q <= '0;
      q.cls <= CLS_NOP;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      q <= d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  assign {pc_out, funct3, funct7, src_sel, alu_en, op_a_pc, immediate,
          rs1_addr, rs2_addr, rd_addr, rd_we, cls} = q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ill_q <= 1'b0;
    else if (load) ill_q <= bad;
  end
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif
endmodule
